mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/mem_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-interface controller: word width,
// memory RW encoding and the access FSM state encoding.
package mem_ctrl_pkg;

  // Width of addresses and data words exchanged with memory
  localparam int WORD_W = 16;

  // RW levels as the memory expects them
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Access sequencing states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ASSERT  = 3'd2,
    S_RELEASE = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  // Metastability filter: first flop may go metastable, second settles it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      // stage p0: raw capture of the asynchronous input
      sync_p0 <= d;
      // stage p1: settled copy used by downstream logic
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/mem_ctrl.sv
// Memory-interface controller: latches a request from the control unit,
// drives address/data/RW to memory, pulses EN and hand-shakes on MFC with a
// per-edge timeout, then reports completion with a one-cycle DONE.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SETUP_CYCLES   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              REQ,
  input  logic              WR,
  input  logic [WORD_W-1:0] ADDR,
  input  logic [WORD_W-1:0] WDATA,
  output logic [WORD_W-1:0] RDATA,
  output logic              DONE,
  output logic              BUSY,
  output logic              ERR,
  output logic [WORD_W-1:0] MAR_to_MEM,
  output logic [WORD_W-1:0] MDR_to_MEM,
  output logic              EN,
  output logic              RW,
  input  logic [WORD_W-1:0] MEM_to_MDR,
  input  logic              MFC
);

  // Timeout counter is one bit wider than needed so it can never wrap
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int SET_W = $clog2(SETUP_CYCLES + 1) + 1;

  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_FIRST = SET_W'(SETUP_CYCLES - 1);

  state_t             state;
  logic [SET_W-1:0]   setup_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               mfc_sync;

  // MFC is asynchronous to clk; the FSM only ever looks at the settled copy
  sync_2ff u_mfc_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (MFC),
    .q     (mfc_sync)
  );

  // Access sequencer: request capture, setup hold, EN handshake, completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      EN         <= 1'b0;
      RW         <= RW_READ;
      MAR_to_MEM <= '0;
      MDR_to_MEM <= '0;
      RDATA      <= '0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      setup_cnt  <= '0;
      tmo_cnt    <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          // Address, data and direction are frozen here for the whole access
          if (REQ) begin
            MAR_to_MEM <= ADDR;
            MDR_to_MEM <= WDATA;
            RW         <= WR ? RW_WRITE : RW_READ;
            ERR        <= 1'b0;
            setup_cnt  <= SET_FIRST;
            state      <= S_SETUP;
          end
        end

        S_SETUP: begin
          // Hold the bus quiet with EN low so memory sees stable inputs
          if (setup_cnt == '0) begin
            EN      <= 1'b1;
            tmo_cnt <= '0;
            state   <= S_ASSERT;
          end else begin
            setup_cnt <= setup_cnt - SET_W'(1);
          end
        end

        S_ASSERT: begin
          if (mfc_sync) begin
            // Read data is valid while MFC is high; take it before dropping EN
            if (RW == RW_READ) begin
              MDR_to_MEM <= MEM_to_MDR;
              RDATA      <= MEM_to_MDR;
            end
            EN      <= 1'b0;
            tmo_cnt <= '0;
            state   <= S_RELEASE;
          end else if (tmo_cnt == TMO_LAST) begin
            // Memory never answered: abandon without touching the data path
            ERR     <= 1'b1;
            EN      <= 1'b0;
            tmo_cnt <= '0;
            state   <= S_RELEASE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        S_RELEASE: begin
          // Wait for memory to withdraw MFC so the next access starts clean
          if (!mfc_sync) begin
            DONE  <= 1'b1;
            state <= S_FINISH;
          end else if (tmo_cnt == TMO_LAST) begin
            ERR   <= 1'b1;
            DONE  <= 1'b1;
            state <= S_FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        S_FINISH: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: a simple asynchronous memory device answers EN with
// MFC, a transaction-level reference predicts every access outcome, and a
// per-cycle compare process checks the controller against it.
module tb_mem_ctrl;

  localparam int TIMEOUT_CYCLES = 64;
  localparam int SETUP_CYCLES   = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        REQ;
  logic        WR;
  logic [15:0] ADDR;
  logic [15:0] WDATA;
  logic [15:0] RDATA;
  logic        DONE;
  logic        BUSY;
  logic        ERR;
  logic [15:0] MAR_to_MEM;
  logic [15:0] MDR_to_MEM;
  logic        EN;
  logic        RW;
  logic [15:0] MEM_to_MDR;
  logic        MFC;

  mem_ctrl #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SETUP_CYCLES   (SETUP_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .REQ        (REQ),
    .WR         (WR),
    .ADDR       (ADDR),
    .WDATA      (WDATA),
    .RDATA      (RDATA),
    .DONE       (DONE),
    .BUSY       (BUSY),
    .ERR        (ERR),
    .MAR_to_MEM (MAR_to_MEM),
    .MDR_to_MEM (MDR_to_MEM),
    .EN         (EN),
    .RW         (RW),
    .MEM_to_MDR (MEM_to_MDR),
    .MFC        (MFC)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    bit          tmo;
  } txn_t;

  txn_t        exp_q[$];
  logic [15:0] ref_mem [0:255];
  logic [15:0] dev_mem [0:255];
  logic [15:0] exp_rdata = 16'h0000;
  logic        exp_err   = 1'b0;
  int          checks    = 0;
  int          failures  = 0;
  int          done_count = 0;
  int          en_run = 0;
  int          last_en_len = 0;
  bit          prev_done = 1'b0;
  bit          mfc_enable = 1'b1;

  function automatic logic [15:0] init_word(input int a);
    case (a)
      0:       return 16'h800A;
      1:       return 16'hF0FF;
      2:       return 16'h1043;
      6:       return 16'hD0C1;
      default: return 16'(a) ^ 16'h5A5A;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Memory device: samples the bus on EN rise, answers with MFC a little later
  always @(posedge EN) begin
    if (RW) MEM_to_MDR = dev_mem[MAR_to_MEM[7:0]];
    else    dev_mem[MAR_to_MEM[7:0]] = MDR_to_MEM;
    if (mfc_enable) begin
      #3;
      MFC = 1'b1;
    end
  end

  // Memory device: withdraws MFC shortly after EN falls
  always @(negedge EN) begin
    #3;
    MFC = 1'b0;
  end

  // Compare process: checks DUT outputs against the transaction reference
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      en_run    = 0;
      prev_done = 1'b0;
    end else begin
      if (EN === 1'b1) begin
        en_run++;
        if (exp_q.size() == 0) fail_now("en_without_request");
        else begin
          check("mar_stable", 32'(MAR_to_MEM), 32'(exp_q[0].addr));
          check("rw_stable", 32'(RW), exp_q[0].wr ? 32'd0 : 32'd1);
          if (exp_q[0].wr) check("mdr_stable", 32'(MDR_to_MEM), 32'(exp_q[0].wdata));
        end
      end else if (en_run != 0) begin
        last_en_len = en_run;
        en_run      = 0;
      end

      if (DONE === 1'b1) begin
        txn_t t;
        done_count++;
        if (prev_done) fail_now("done_wider_than_one_cycle");
        if (exp_q.size() == 0) fail_now("done_unexpected");
        else begin
          t = exp_q.pop_front();
          if (!t.wr && !t.tmo) exp_rdata = t.rdata;
          exp_err = t.tmo;
          check("done_rdata", 32'(RDATA), 32'(exp_rdata));
          check("done_err", 32'(ERR), 32'(exp_err));
          check("done_mar", 32'(MAR_to_MEM), 32'(t.addr));
          if (t.tmo) check("timeout_en_len", 32'(last_en_len), 32'(TIMEOUT_CYCLES));
          else if (!t.wr) check("done_mdr_capture", 32'(MDR_to_MEM), 32'(t.rdata));
        end
      end
      prev_done = (DONE === 1'b1);

      if (BUSY === 1'b0) begin
        check("idle_rdata", 32'(RDATA), 32'(exp_rdata));
        check("idle_err", 32'(ERR), 32'(exp_err));
        check("idle_en", 32'(EN), 32'd0);
      end
    end
  end

  task automatic push_txn(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                          input bit tmo);
    txn_t t;
    t.wr    = wr;
    t.addr  = addr;
    t.wdata = wdata;
    t.tmo   = tmo;
    t.rdata = ref_mem[addr[7:0]];
    if (wr && !tmo) ref_mem[addr[7:0]] = wdata;
    exp_q.push_back(t);
  endtask

  // Present a request for one cycle, then scramble the inputs
  task automatic issue(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                       input bit tmo);
    push_txn(wr, addr, wdata, tmo);
    WR    = wr;
    ADDR  = addr;
    WDATA = wdata;
    REQ   = 1'b1;
    @(posedge clk);
    #1;
    REQ   = 1'b0;
    ADDR  = ~addr;
    WDATA = ~wdata;
    WR    = ~wr;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (DONE !== 1'b1 && n < budget);
    check({name, "_done_seen"}, 32'(DONE), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (EN !== 1'b1 && n < budget);
    check({name, "_en_seen"}, 32'(EN), 32'd1);
  endtask

  initial begin
    int d0;
    for (int a = 0; a < 256; a++) begin
      ref_mem[a] = init_word(a);
      dev_mem[a] = init_word(a);
    end
    MFC        = 1'b0;
    MEM_to_MDR = 16'h0000;
    rst_n      = 1'b0;
    REQ        = 1'b0;
    WR         = 1'b0;
    ADDR       = 16'h0000;
    WDATA      = 16'h0000;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", 32'(EN), 32'd0);
    check("rst_rw", 32'(RW), 32'd1);
    check("rst_mar", 32'(MAR_to_MEM), 32'd0);
    check("rst_mdr", 32'(MDR_to_MEM), 32'd0);
    check("rst_rdata", 32'(RDATA), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Read 0x0000 with EN-rise latency check
    issue(1'b0, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < SETUP_CYCLES; i++) begin
      @(negedge clk);
      check("lat_en_low", 32'(EN), 32'd0);
    end
    @(negedge clk);
    check("lat_en_high", 32'(EN), 32'd1);
    wait_done("read0", 100);
    check("read0_rdata", 32'(RDATA), 32'h800A);
    check("read0_err", 32'(ERR), 32'd0);

    // Write 0x0010 then read it back
    issue(1'b1, 16'h0010, 16'h1234, 1'b0);
    wait_done("write10", 100);
    check("write10_rdata_kept", 32'(RDATA), 32'h800A);
    issue(1'b0, 16'h0010, 16'h0000, 1'b0);
    wait_done("read10", 100);
    check("read10_rdata", 32'(RDATA), 32'h1234);

    // Timeout: memory never answers
    mfc_enable = 1'b0;
    issue(1'b0, 16'h0003, 16'h0000, 1'b1);
    wait_done("tmo", 300);
    check("tmo_err", 32'(ERR), 32'd1);
    check("tmo_rdata_kept", 32'(RDATA), 32'h1234);
    mfc_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset while EN is high abandons the access
    issue(1'b0, 16'h0002, 16'h0000, 1'b0);
    wait_en("rst_mid", 50);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_rdata = 16'h0000;
    exp_err   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_mid_en", 32'(EN), 32'd0);
    check("rst_mid_busy", 32'(BUSY), 32'd0);
    check("rst_mid_done", 32'(DONE), 32'd0);
    d0 = done_count;
    repeat (10) @(posedge clk);
    #1;
    check("rst_mid_no_done", 32'(done_count), 32'(d0));
    issue(1'b0, 16'h0001, 16'h0000, 1'b0);
    wait_done("read1", 100);
    check("read1_rdata", 32'(RDATA), 32'hF0FF);

    // REQ while busy is ignored
    issue(1'b0, 16'h0000, 16'h0000, 1'b0);
    wait_en("busyreq", 50);
    @(posedge clk);
    #1;
    REQ   = 1'b1;
    ADDR  = 16'h0005;
    WR    = 1'b1;
    WDATA = 16'hBEEF;
    @(posedge clk);
    #1;
    REQ = 1'b0;
    check("busyreq_mar_mid", 32'(MAR_to_MEM), 32'h0000);
    wait_done("busyreq", 100);
    check("busyreq_mar_end", 32'(MAR_to_MEM), 32'h0000);
    check("busyreq_rdata", 32'(RDATA), 32'h800A);
    repeat (8) @(posedge clk);
    #1;
    check("busyreq_no_reissue", 32'(BUSY), 32'd0);

    // REQ held high: two back-to-back reads
    push_txn(1'b0, 16'h0002, 16'h0000, 1'b0);
    push_txn(1'b0, 16'h0006, 16'h0000, 1'b0);
    WR   = 1'b0;
    ADDR = 16'h0002;
    REQ  = 1'b1;
    @(posedge clk);
    #1;
    ADDR = 16'h0006;
    wait_done("held1", 100);
    check("held1_rdata", 32'(RDATA), 32'h1043);
    @(posedge clk);
    #1;
    REQ = 1'b0;
    check("held2_accepted", 32'(BUSY), 32'd1);
    wait_done("held2", 100);
    check("held2_rdata", 32'(RDATA), 32'hD0C1);
    repeat (5) @(posedge clk);
    #1;
    check("all_txn_done", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
